wb_scoreboard: RTL and testbench



---
 rtl/wb_scoreboard_if.sv | 69 ++++++
 rtl/wb_scoreboard.sv | 86 ++++++++
 tb/tb_wb_scoreboard.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_scoreboard_if.sv
// Shared types and the issue/writeback/regfile bundle of the writeback scoreboard.
package wb_scoreboard_pkg;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NREG   = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    addr_t addr;
    word_t data;
  } wb_req_t;
endpackage

interface wb_scoreboard_if;
  import wb_scoreboard_pkg::*;

  logic  issue_valid;
  addr_t issue_rs1;
  addr_t issue_rs2;
  addr_t issue_rd;
  logic  issue_rd_en;
  logic  issue_ready;

  logic  wb0_valid;
  addr_t wb0_addr;
  word_t wb0_data;
  logic  wb0_ready;
  logic  wb1_valid;
  addr_t wb1_addr;
  word_t wb1_data;
  logic  wb1_ready;

  logic  rd_en;
  addr_t rd_addr;
  word_t rd_data;

  word_t rf_rs1_data;
  word_t rf_rs2_data;
  word_t rs1_data;
  word_t rs2_data;

  logic  busy;

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en,
    output issue_ready,
    input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    output wb0_ready, wb1_ready,
    output rd_en, rd_addr, rd_data,
    input  rf_rs1_data, rf_rs2_data,
    output rs1_data, rs2_data,
    output busy
  );

  // Decode, writeback sources and register file side.
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en,
    input  issue_ready,
    output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    input  wb0_ready, wb1_ready,
    input  rd_en, rd_addr, rd_data,
    output rf_rs1_data, rf_rs2_data,
    input  rs1_data, rs2_data,
    input  busy
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Register-file write scoreboard: RAW/WAW issue stall plus round-robin writeback arbitration.
// Optional macro WB_BYPASS_EN forwards the write in progress to the hazard check and operands.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int unsigned NSRC       = 2,
  parameter int unsigned RESET_PRIO = 0
) (
  input logic            clk,
  input logic            reset,
  wb_scoreboard_if.slave sb
);

  logic [NREG-1:0] pending_q, pending_d;
  logic            prio_q, prio_d;

  logic [NSRC-1:0] gnt_c;
  wb_req_t         win_c;
  logic            wr_en_c;
  logic [NREG-1:0] clr_c, set_c, chk_c;
  logic            hazard_c, ready_c, fire_c;

  // Round-robin grant; a lone valid source always wins.
  always_comb begin
    gnt_c = '0;
    if (!reset) begin
      if (sb.wb0_valid && (!sb.wb1_valid || (prio_q == 1'b0))) begin
        gnt_c[0] = 1'b1;
      end else if (sb.wb1_valid) begin
        gnt_c[1] = 1'b1;
      end
    end
    win_c   = gnt_c[1] ? '{addr: sb.wb1_addr, data: sb.wb1_data}
                       : '{addr: sb.wb0_addr, data: sb.wb0_data};
    wr_en_c = (|gnt_c) && (win_c.addr != '0);
  end

  // Hazard check and pending-bit update; a set beats a clear of the same bit.
  always_comb begin
    clr_c = wr_en_c ? (NREG'(1) << win_c.addr) : '0;
`ifdef WB_BYPASS_EN
    chk_c = pending_q & ~clr_c;
`else
    chk_c = pending_q;
`endif
    hazard_c = ((sb.issue_rs1 != '0) && chk_c[sb.issue_rs1]) ||
               ((sb.issue_rs2 != '0) && chk_c[sb.issue_rs2]) ||
               (sb.issue_rd_en && (sb.issue_rd != '0) && chk_c[sb.issue_rd]);
    ready_c  = !reset && !hazard_c;
    fire_c   = sb.issue_valid && ready_c && sb.issue_rd_en && (sb.issue_rd != '0);
    set_c    = fire_c ? (NREG'(1) << sb.issue_rd) : '0;

    pending_d    = (pending_q & ~clr_c) | set_c;
    pending_d[0] = 1'b0;
    prio_d       = (|gnt_c) ? gnt_c[0] : prio_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      prio_q    <= 1'(RESET_PRIO);
    end else begin
      pending_q <= pending_d;
      prio_q    <= prio_d;
    end
  end

  assign sb.issue_ready = ready_c;
  assign sb.wb0_ready   = gnt_c[0];
  assign sb.wb1_ready   = gnt_c[1];
  assign sb.rd_en       = wr_en_c;
  assign sb.rd_addr     = (|gnt_c) ? win_c.addr : '0;
  assign sb.rd_data     = (|gnt_c) ? win_c.data : '0;
  assign sb.busy        = !reset && (|pending_q);

`ifdef WB_BYPASS_EN
  assign sb.rs1_data = (wr_en_c && (sb.issue_rs1 != '0) && (win_c.addr == sb.issue_rs1))
                       ? win_c.data : sb.rf_rs1_data;
  assign sb.rs2_data = (wr_en_c && (sb.issue_rs2 != '0) && (win_c.addr == sb.issue_rs2))
                       ? win_c.data : sb.rf_rs2_data;
`else
  assign sb.rs1_data = sb.rf_rs1_data;
  assign sb.rs2_data = sb.rf_rs2_data;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench: expected regfile writes are queued by stimulus and checked by a write monitor.
module tb_wb_scoreboard;
  import wb_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_req_t exp_q[$];

  wb_scoreboard_if ifc ();

  wb_scoreboard #(.NSRC(2), .RESET_PRIO(0)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (ifc)
  );

  always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every regfile write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && ifc.rd_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected none", ifc.rd_addr, ifc.rd_data);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ifc.rd_addr), 32'(e.addr));
        chk("wr_data", ifc.rd_data, e.data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.issue_valid = 1'b0; ifc.issue_rd_en = 1'b0;
    ifc.issue_rs1 = '0; ifc.issue_rs2 = '0; ifc.issue_rd = '0;
    ifc.wb0_valid = 1'b0; ifc.wb0_addr = '0; ifc.wb0_data = '0;
    ifc.wb1_valid = 1'b0; ifc.wb1_addr = '0; ifc.wb1_data = '0;
  endtask

  task automatic issue_write(input addr_t rd);
    ifc.issue_valid = 1'b1; ifc.issue_rd_en = 1'b1; ifc.issue_rd = rd;
    ifc.issue_rs1 = '0; ifc.issue_rs2 = '0;
    @(negedge clk);
    chk("issue_ready_free", 32'(ifc.issue_ready), 32'd1);
    next_cycle();
    ifc.issue_valid = 1'b0; ifc.issue_rd_en = 1'b0; ifc.issue_rd = '0;
  endtask

  initial begin
    ifc.rf_rs1_data = 32'h1111_0001;
    ifc.rf_rs2_data = 32'h5555_5555;
    idle_inputs();
    reset = 1'b1;
    // Outputs stay quiet under reset even with requests present.
    ifc.wb0_valid = 1'b1; ifc.wb0_addr = 5'd3; ifc.wb0_data = 32'hAAAA_0000;
    ifc.issue_valid = 1'b1;
    @(negedge clk);
    chk("rst_issue_ready", 32'(ifc.issue_ready), 32'd0);
    chk("rst_wb0_ready",   32'(ifc.wb0_ready),   32'd0);
    chk("rst_rd_en",       32'(ifc.rd_en),       32'd0);
    chk("rst_rd_addr",     32'(ifc.rd_addr),     32'd0);
    chk("rst_rd_data",     ifc.rd_data,          32'd0);
    chk("rst_busy",        32'(ifc.busy),        32'd0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();

    // RAW on rd=5 then writeback clears it.
    @(negedge clk);
    chk("idle_rd_addr", 32'(ifc.rd_addr), 32'd0);
    chk("idle_rd_data", ifc.rd_data, 32'd0);
    next_cycle();
    issue_write(5'd5);
    ifc.issue_rs1 = 5'd5;
    @(negedge clk);
    chk("busy_after_issue", 32'(ifc.busy), 32'd1);
    chk("raw_rs1_stall", 32'(ifc.issue_ready), 32'd0);
    next_cycle();
    ifc.wb0_valid = 1'b1; ifc.wb0_addr = 5'd5; ifc.wb0_data = 32'hDEAD_BEEF;
    exp_q.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
    @(negedge clk);
    chk("wb0_ready_single", 32'(ifc.wb0_ready), 32'd1);
    chk("wb1_ready_single", 32'(ifc.wb1_ready), 32'd0);
    chk("raw_during_wb", 32'(ifc.issue_ready), 32'(BYP));
    next_cycle();
    ifc.wb0_valid = 1'b0;
    @(negedge clk);
    chk("raw_cleared", 32'(ifc.issue_ready), 32'd1);
    chk("busy_cleared", 32'(ifc.busy), 32'd0);
    next_cycle();
    idle_inputs();

    // Reset pulse returns priority to source 0.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;

    // Both sources valid for four cycles: grants alternate 0,1,0,1.
    ifc.wb0_valid = 1'b1; ifc.wb0_addr = 5'd3; ifc.wb0_data = 32'h0000_00A3;
    ifc.wb1_valid = 1'b1; ifc.wb1_addr = 5'd7; ifc.wb1_data = 32'h0000_00B7;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_q.push_back('{addr: 5'd3, data: 32'h0000_00A3});
      else            exp_q.push_back('{addr: 5'd7, data: 32'h0000_00B7});
      @(negedge clk);
      chk("rr_wb0_ready", 32'(ifc.wb0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_wb1_ready", 32'(ifc.wb1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    idle_inputs();

    // rd=0 never becomes pending; a writeback to x0 is consumed without a write.
    issue_write(5'd0);
    @(negedge clk);
    chk("x0_not_busy", 32'(ifc.busy), 32'd0);
    next_cycle();
    ifc.wb1_valid = 1'b1; ifc.wb1_addr = 5'd0; ifc.wb1_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("x0_wb1_ready", 32'(ifc.wb1_ready), 32'd1);
    chk("x0_rd_en", 32'(ifc.rd_en), 32'd0);
    next_cycle();
    idle_inputs();

    // WAW on rd=9 stalls until the writeback.
    issue_write(5'd9);
    ifc.issue_rd_en = 1'b1; ifc.issue_rd = 5'd9;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("waw_stall", 32'(ifc.issue_ready), 32'd0);
      next_cycle();
    end
    ifc.wb1_valid = 1'b1; ifc.wb1_addr = 5'd9; ifc.wb1_data = 32'h0000_0909;
    exp_q.push_back('{addr: 5'd9, data: 32'h0000_0909});
    @(negedge clk);
    chk("waw_during_wb", 32'(ifc.issue_ready), 32'(BYP));
    next_cycle();
    ifc.wb1_valid = 1'b0;
    @(negedge clk);
    chk("waw_cleared", 32'(ifc.issue_ready), 32'd1);
    next_cycle();
    idle_inputs();

    // Forwarding case on rs2=12.
    issue_write(5'd12);
    ifc.issue_rs2 = 5'd12;
    ifc.wb0_valid = 1'b1; ifc.wb0_addr = 5'd12; ifc.wb0_data = 32'h0000_1234;
    exp_q.push_back('{addr: 5'd12, data: 32'h0000_1234});
    @(negedge clk);
    chk("byp_ready", 32'(ifc.issue_ready), 32'(BYP));
    chk("byp_rs2_data", ifc.rs2_data, BYP ? 32'h0000_1234 : 32'h5555_5555);
    chk("byp_rs1_data", ifc.rs1_data, 32'h1111_0001);
    next_cycle();
    ifc.wb0_valid = 1'b0;
    @(negedge clk);
    chk("byp_next_ready", 32'(ifc.issue_ready), 32'd1);
    chk("byp_next_rs2", ifc.rs2_data, 32'h5555_5555);
    next_cycle();
    idle_inputs();

    // Reset with pending {4,8} discards them; a late result still writes.
    issue_write(5'd4);
    issue_write(5'd8);
    ifc.issue_rs1 = 5'd4; ifc.issue_rs2 = 5'd8;
    @(negedge clk);
    chk("pend48_busy", 32'(ifc.busy), 32'd1);
    chk("pend48_stall", 32'(ifc.issue_ready), 32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(ifc.busy), 32'd0);
    chk("post_rst_ready", 32'(ifc.issue_ready), 32'd1);
    next_cycle();
    ifc.wb0_valid = 1'b1; ifc.wb0_addr = 5'd4; ifc.wb0_data = 32'h0000_0444;
    exp_q.push_back('{addr: 5'd4, data: 32'h0000_0444});
    @(negedge clk);
    chk("late_wb_ready", 32'(ifc.wb0_ready), 32'd1);
    next_cycle();
    ifc.wb0_valid = 1'b0;
    @(negedge clk);
    chk("late_wb_busy", 32'(ifc.busy), 32'd0);
    next_cycle();
    idle_inputs();

    repeat (2) next_cycle();
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete within 20000 time units");
    $fatal(1, "timeout");
  end
endmodule
